// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-64 demultiplexer.
//   SEL_W / N_OUT     : full select width and lane count
//   GRP_SEL_W / GRP_N : per-stage select width and fan-out of each 1-to-8 stage
//   lane_mask()       : one-hot lane mask for a given select code
package demux_pkg;

    localparam int unsigned SEL_W     = 6;
    localparam int unsigned N_OUT     = 64;
    localparam int unsigned GRP_SEL_W = 3;
    localparam int unsigned GRP_N     = 8;

    function automatic logic [N_OUT-1:0] lane_mask(input logic [SEL_W-1:0] s);
        logic [N_OUT-1:0] m;
        m    = '0;
        m[s] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/demux_1to8.sv
// Combinational 1-to-8 demux stage.
//   in  : data to steer (DATA_W bits)
//   sel : destination lane 0..7
//   out : 8 lanes, lane k = out[k*DATA_W +: DATA_W]; unselected lanes are zero
module demux_1to8
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = 1
) (
    input  logic [DATA_W-1:0]       in,
    input  logic [GRP_SEL_W-1:0]    sel,
    output logic [GRP_N*DATA_W-1:0] out
);

    always_comb begin
        out = '0;
        for (int k = 0; k < int'(GRP_N); k++) begin
            if (sel == GRP_SEL_W'(k)) begin
                out[k*DATA_W +: DATA_W] = in;
            end
        end
    end

endmodule

// File: rtl/demux_1to64.sv
// Registered 1-to-64 demultiplexer built from a two-level tree of 1-to-8 stages.
//   clk : system clock, rising edge
//   rst : synchronous reset, active-high, clears out
//   in  : data to steer (DATA_W bits)
//   sel : destination lane 0..63
//   out : registered lanes, lane k = out[k*DATA_W +: DATA_W], one cycle after in/sel
module demux_1to64
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       in,
    input  logic [SEL_W-1:0]        sel,
    output logic [N_OUT*DATA_W-1:0] out
);

    // Group enables from level 1; each group carries the full data word.
    logic [GRP_N*DATA_W-1:0] grp;
    logic [N_OUT*DATA_W-1:0] out_d;
    logic [N_OUT*DATA_W-1:0] out_q;

    // Stage 0 is level 1 (upper select bits); stages 1..8 are level 2, one per group.
    for (genvar i = 0; i <= int'(GRP_N); i++) begin : g_stage
        if (i == 0) begin : g_lvl1
            demux_1to8 #(
                .DATA_W (DATA_W)
            ) u_demux (
                .in  (in),
                .sel (sel[SEL_W-1:GRP_SEL_W]),
                .out (grp)
            );
        end else begin : g_lvl2
            demux_1to8 #(
                .DATA_W (DATA_W)
            ) u_demux (
                .in  (grp[(i-1)*DATA_W +: DATA_W]),
                .sel (sel[GRP_SEL_W-1:0]),
                .out (out_d[(i-1)*GRP_N*DATA_W +: GRP_N*DATA_W])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_demux_1to64.sv
module tb_demux_1to64;
    import demux_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in;
    logic [5:0]  sel;
    logic [63:0] out;

    typedef struct {
        string       name;
        logic        rst;
        logic        in;
        logic [5:0]  sel;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [63:0] exp;
    } sb_t;

    sb_t  sb[$];
    vec_t vecs[15];
    int   errors = 0;
    int   checks = 0;

    demux_1to64 #(
        .DATA_W (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .sel (sel),
        .out (out)
    );

    always #5 clk = ~clk;

    // Drive on the falling edge, push the expectation, compare 1 time unit after the rising edge.
    task automatic apply(input string name, input logic r, input logic d, input logic [5:0] s,
                         input logic [63:0] exp);
        sb_t e;
        @(negedge clk);
        rst = r;
        in  = d;
        sel = s;
        sb.push_back('{name: name, exp: exp});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s: scoreboard empty, got %h", name, out);
        end else begin
            e = sb.pop_front();
            checks++;
            if (out !== e.exp) begin
                errors++;
                $display("FAIL %s: sel=%0d in=%0b rst=%0b got %h required %h",
                         e.name, s, d, r, out, e.exp);
            end
        end
    endtask

    initial begin
        logic        r;
        logic        d;
        logic [5:0]  s;
        logic [63:0] one;

        one = 64'h1;

        vecs[0]  = '{"rst_edge0",  1'b1, 1'b1, 6'd5,  64'h0};
        vecs[1]  = '{"rst_edge1",  1'b1, 1'b1, 6'd5,  64'h0};
        vecs[2]  = '{"rst_release",1'b0, 1'b1, 6'd5,  64'h20};
        vecs[3]  = '{"wrap_7",     1'b0, 1'b1, 6'd7,  64'h80};
        vecs[4]  = '{"wrap_8",     1'b0, 1'b1, 6'd8,  64'h100};
        vecs[5]  = '{"wrap_63",    1'b0, 1'b1, 6'd63, 64'h8000_0000_0000_0000};
        vecs[6]  = '{"wrap_0",     1'b0, 1'b1, 6'd0,  64'h1};
        vecs[7]  = '{"simul_pre",  1'b0, 1'b1, 6'd3,  64'h8};
        vecs[8]  = '{"simul_chg",  1'b0, 1'b0, 6'd40, 64'h0};
        vecs[9]  = '{"simul_hold", 1'b0, 1'b1, 6'd40, 64'h100_0000_0000};
        vecs[10] = '{"mid_pre",    1'b0, 1'b1, 6'd12, 64'h1000};
        vecs[11] = '{"mid_rst",    1'b1, 1'b1, 6'd12, 64'h0};
        vecs[12] = '{"mid_release",1'b0, 1'b1, 6'd12, 64'h1000};
        vecs[13] = '{"grp_55",     1'b0, 1'b1, 6'd55, 64'h0080_0000_0000_0000};
        vecs[14] = '{"grp_56",     1'b0, 1'b1, 6'd56, 64'h0100_0000_0000_0000};

        rst = 1'b1;
        in  = 1'b0;
        sel = 6'd0;

        for (int i = 0; i < 15; i++) begin
            apply(vecs[i].name, vecs[i].rst, vecs[i].in, vecs[i].sel, vecs[i].exp);
        end

        // One-hot walk with an independent shift model.
        for (int i = 0; i < 64; i++) begin
            apply("walk_one", 1'b0, 1'b1, 6'(i), one << i);
        end

        for (int i = 0; i < 64; i++) begin
            apply("walk_zero", 1'b0, 1'b0, 6'(i), 64'h0);
        end

        // Random pairs, including occasional reset, against the package mask model.
        for (int i = 0; i < 40; i++) begin
            r = ($urandom_range(0, 7) == 0);
            d = 1'($urandom_range(0, 1));
            s = 6'($urandom_range(0, 63));
            apply("random", r, d, s, (r || !d) ? 64'h0 : lane_mask(s));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
